ram_port_b_loader: RTL and testbench
====================================

# ram_port_b_loader

- Byte-stream command engine that drives the 16-bit port B of the dual-port program/data RAM.
- Host link (UART or debug bridge) sends byte commands to load memory images or dump RAM contents back, while the CPU keeps port A.
- Assembles big-endian 16-bit words, issues single-cycle port-B writes, and serialises port-B reads into a byte stream.
- Adapts to the RAM's one-cycle registered-address read latency.

## Interface
- DATA_WIDTH, 32, port-A word width of the attached RAM; legal values 16, 32, 64.
- ADDR_WIDTH, 10 + DATA_WIDTH/16 - 1, port-B address width (11 at default).

Ports (all synchronous to `clock`):
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and output reset values immediately.
- rx_data  in  8  incoming command/data byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  byte accepted on edge where rx_valid && rx_ready.
- tx_data  out  8  outgoing dump byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  byte consumed on edge where tx_valid && tx_ready.
- address_b  out  ADDR_WIDTH  RAM port-B address (registered).
- data_b  out  16  RAM port-B write data (registered).
- wren_b  out  1  RAM port-B write enable (registered, one-cycle pulse).
- q_b  in  16  RAM port-B read data; valid one cycle after address_b is sampled by RAM.
- busy  out  1  high whenever state != IDLE.

## Operation
- **Command format:** all multi-byte fields are MSB first.
  - Write: cmd, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then 2·CNT data bytes.
  - cmd = 0x57 ('W') is write; cmd = 0x52 ('R') is read.
- **Field handling:**
  - Start address = low ADDR_WIDTH bits of the 16-bit address field; upper bits are ignored.
  - CNT is an unsigned 16-bit word count. CNT = 0 returns to IDLE after CNT_LO with no RAM or tx activity.
  - Any other byte in IDLE is accepted and dropped; state stays IDLE.
- **States:** IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, WR_HI, WR_LO, RD_ADDR, RD_WAIT, RD_CAP, TX_HI, TX_LO.
  - IDLE→ADDR_HI on a valid command byte; then one state per accepted header byte.
  - CNT_LO→WR_HI (W) or RD_ADDR (R), or →IDLE when CNT = 0.
- **rx_ready:** decoded from state. 1 in IDLE, header states, WR_HI, WR_LO. 0 in all read/tx states.
- **Write path:**
  - WR_HI stores the high byte.
  - On the edge accepting the WR_LO byte: address_b <= addr, data_b <= {hi, lo}, wren_b <= 1.
  - On that same edge: addr <= addr + 1 (mod 2^ADDR_WIDTH), count <= count - 1.
  - Next state is WR_HI, or IDLE if count reaches 0.
  - wren_b is high for exactly one cycle per word and cleared on the following edge.
- **Read path:**
  - RD_ADDR: address_b <= addr at the exit edge.
  - RD_WAIT: RAM registers the address.
  - RD_CAP: word register <= q_b; addr increments and count decrements.
  - TX_HI: presents word[15:8].
  - TX_LO: presents word[7:0].
  - After the TX_LO handshake: next state is RD_ADDR, or IDLE if count = 0.
- **tx side:**
  - tx_valid = 1 only in TX_HI/TX_LO.
  - tx_data is held stable until the handshake.
  - wren_b is never asserted in read states.
- **Address wrap:** address increments wrap silently at 2^ADDR_WIDTH for both write and read.

## Timing
- **Reset values:** rx_ready=1 (IDLE), tx_valid=0, tx_data=0, address_b=0, data_b=0, wren_b=0, busy=0.
- **Reset mid-operation:**
  - Immediate return to IDLE.
  - A partially assembled word is discarded; no wren_b pulse is issued for it.
  - Any pending tx byte is dropped.
- **Write latency:** wren_b is visible the cycle after the low data byte is accepted; the RAM writes on the next edge.
  - Sustained throughput is one word per two accepted rx bytes, with no stall cycles.
- **Read latency:** tx_valid rises after the 3rd rising edge following the edge that accepted CNT_LO (first word).
  - Same 3-edge delay after the TX_LO handshake (subsequent words).
  - Per-word minimum is 5 cycles with tx_ready held at 1.
- **busy:** rises on the edge accepting the command byte. Falls on the edge of the final wren_b issue (write) or the final TX_LO handshake (read).

## Test plan
- **Write:**
  - Stimulus: rx 57 00 10 00 02 AB CD 12 34.
  - Required: wren_b single-cycle pulses at address_b 0x010/data_b 0xABCD, then 0x011/0x1234; busy low afterward.
- **Read-back:**
  - Stimulus: rx 52 00 10 00 02 with tx_ready=1.
  - Required: tx bytes AB CD 12 34 in order; first tx_valid 3 edges after CNT_LO accept; rx_ready=0 throughout the read.
- **Wrap and address masking:**
  - Stimulus: write 57 FF FF 00 02 11 11 22 22.
  - Required: writes at 0x7FF then 0x000.
  - Stimulus: read 52 07 FF 00 02.
  - Required: returns 11 11 22 22.
- **Backpressure:**
  - Stimulus: during read, tx_ready=0 for 10 cycles.
  - Required: tx_valid stays 1; tx_data stable at high byte; address_b unchanged; no extra RAM reads.
- **Junk and empty:**
  - Stimulus: rx 41.
  - Required: accepted, busy stays 0, no wren_b.
  - Stimulus: rx 57 00 20 00 00.
  - Required: busy returns 0 after CNT_LO; no wren_b; no tx.
- **Reset mid-write:**
  - Stimulus: assert reset after 57 00 30 00 01 AB.
  - Required: outputs return to reset values immediately; wren_b never pulses.
  - Then: a fresh write of 0x5555 to 0x030 succeeds.

Source files
------------

// File: rtl/ram_port_b_loader.sv
// Byte-stream command engine for port B of the dual-port program/data RAM.
// Loads big-endian 16-bit words from the host link and dumps RAM words back.
module ram_port_b_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10 + DATA_WIDTH / 16 - 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] address_b,
  output logic [15:0]           data_b,
  output logic                  wren_b,
  input  logic [15:0]           q_b,
  output logic                  busy
);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    CNT_HI,
    CNT_LO,
    WR_HI,
    WR_LO,
    RD_ADDR,
    RD_WAIT,
    RD_CAP,
    TX_HI,
    TX_LO
  } state_t;

  state_t                state, state_n;
  logic                  is_rd, is_rd_n;
  logic [7:0]            ahi, ahi_n;
  logic [7:0]            chi, chi_n;
  logic [7:0]            hi, hi_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [15:0]           count, count_n;
  logic [15:0]           word, word_n;
  logic [ADDR_WIDTH-1:0] address_b_n;
  logic [15:0]           data_b_n;
  logic                  wren_b_n;
  logic [15:0]           addr16;
  logic [15:0]           cnt16;
  logic                  acc;
  logic                  tx_fire;

  assign rx_ready = (state == IDLE)    || (state == ADDR_HI) ||
                    (state == ADDR_LO) || (state == CNT_HI)  ||
                    (state == CNT_LO)  || (state == WR_HI)   ||
                    (state == WR_LO);
  assign tx_valid = (state == TX_HI) || (state == TX_LO);
  assign tx_data  = (state == TX_HI) ? word[15:8] :
                    (state == TX_LO) ? word[7:0]  : 8'h00;
  assign busy     = (state != IDLE);

  assign acc     = rx_valid && rx_ready;
  assign tx_fire = tx_valid && tx_ready;
  assign addr16  = {ahi, rx_data};
  assign cnt16   = {chi, rx_data};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      is_rd     <= 1'b0;
      ahi       <= 8'h00;
      chi       <= 8'h00;
      hi        <= 8'h00;
      addr      <= '0;
      count     <= 16'h0000;
      word      <= 16'h0000;
      address_b <= '0;
      data_b    <= 16'h0000;
      wren_b    <= 1'b0;
    end else begin
      state     <= state_n;
      is_rd     <= is_rd_n;
      ahi       <= ahi_n;
      chi       <= chi_n;
      hi        <= hi_n;
      addr      <= addr_n;
      count     <= count_n;
      word      <= word_n;
      address_b <= address_b_n;
      data_b    <= data_b_n;
      wren_b    <= wren_b_n;
    end
  end

  always_comb begin
    state_n     = state;
    is_rd_n     = is_rd;
    ahi_n       = ahi;
    chi_n       = chi;
    hi_n        = hi;
    addr_n      = addr;
    count_n     = count;
    word_n      = word;
    address_b_n = address_b;
    data_b_n    = data_b;
    wren_b_n    = 1'b0;
    unique case (state)
      IDLE: begin
        // Unknown bytes are consumed and dropped
        if (acc && (rx_data == CMD_W || rx_data == CMD_R)) begin
          is_rd_n = (rx_data == CMD_R);
          state_n = ADDR_HI;
        end
      end
      ADDR_HI: begin
        if (acc) begin
          ahi_n   = rx_data;
          state_n = ADDR_LO;
        end
      end
      ADDR_LO: begin
        if (acc) begin
          addr_n  = addr16[ADDR_WIDTH-1:0];
          state_n = CNT_HI;
        end
      end
      CNT_HI: begin
        if (acc) begin
          chi_n   = rx_data;
          state_n = CNT_LO;
        end
      end
      CNT_LO: begin
        if (acc) begin
          count_n = cnt16;
          if (cnt16 == 16'h0000)
            state_n = IDLE;
          else if (is_rd)
            state_n = RD_ADDR;
          else
            state_n = WR_HI;
        end
      end
      WR_HI: begin
        if (acc) begin
          hi_n    = rx_data;
          state_n = WR_LO;
        end
      end
      WR_LO: begin
        if (acc) begin
          address_b_n = addr;
          data_b_n    = {hi, rx_data};
          wren_b_n    = 1'b1;
          addr_n      = addr + ADDR_WIDTH'(1);
          count_n     = count - 16'd1;
          state_n     = (count == 16'd1) ? IDLE : WR_HI;
        end
      end
      RD_ADDR: begin
        address_b_n = addr;
        state_n     = RD_WAIT;
      end
      RD_WAIT: begin
        // RAM registers address_b on this edge
        state_n = RD_CAP;
      end
      RD_CAP: begin
        word_n  = q_b;
        addr_n  = addr + ADDR_WIDTH'(1);
        count_n = count - 16'd1;
        state_n = TX_HI;
      end
      TX_HI: begin
        if (tx_fire)
          state_n = TX_LO;
      end
      TX_LO: begin
        if (tx_fire)
          state_n = (count == 16'h0000) ? IDLE : RD_ADDR;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_port_b_loader.sv
// Bench for ram_port_b_loader: port-B RAM model plus a word-level
// memory reference; directed test-plan steps followed by random traffic.
module tb_ram_port_b_loader;

  localparam int AW = 11;
  localparam int DEPTH = 2048;

  typedef logic [15:0] wq_t[$];

  logic          clock = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [AW-1:0] address_b;
  logic [15:0]   data_b;
  logic          wren_b;
  logic [15:0]   q_b;
  logic          busy;

  always #5 clock = ~clock;

  ram_port_b_loader dut (
    .clock     (clock),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .address_b (address_b),
    .data_b    (data_b),
    .wren_b    (wren_b),
    .q_b       (q_b),
    .busy      (busy)
  );

  function automatic logic [15:0] pat(int i);
    return 16'(i * 40503) ^ 16'h5A5A;
  endfunction

  // Port-B RAM with registered address
  logic [15:0]   mem [0:DEPTH-1];
  logic [AW-1:0] raddr;
  logic          init_go;

  always @(posedge clock) begin
    if (init_go) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
    end else if (wren_b) begin
      mem[address_b] <= data_b;
    end
    raddr <= address_b;
  end
  assign q_b = mem[raddr];

  logic [7:0]      tx_log[$];
  logic [AW+15:0]  wr_log[$];

  always @(posedge clock) begin
    if (!reset) begin
      if (wren_b) wr_log.push_back({address_b, data_b});
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
    end
  end

  logic [15:0] ref_mem [0:DEPTH-1];
  int checks = 0;
  int failures = 0;
  int tx_idx = 0;
  int wr_idx = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_rx_ready", 32'(rx_ready), 1);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_address_b", 32'(address_b), 0);
    chk("rst_data_b", 32'(data_b), 0);
    chk("rst_wren_b", 32'(wren_b), 0);
    chk("rst_busy", 32'(busy), 0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) chk("rx_ready_timeout", 32'(rx_ready), 1);
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] a,
                          input logic [15:0] cnt);
    send_byte(cmd);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(cnt[15:8]);
    send_byte(cnt[7:0]);
  endtask

  task automatic do_write(input logic [15:0] a, input int cnt,
                          input wq_t fixed);
    int base;
    int loc;
    logic [15:0] w;
    base = int'(a) & (DEPTH - 1);
    send_hdr(8'h57, a, 16'(cnt));
    if (cnt == 0) begin
      chk("empty_busy", 32'(busy), 0);
      @(negedge clock);
      chk("empty_wren", 32'(wren_b), 0);
    end
    for (int i = 0; i < cnt; i++) begin
      w = (i < fixed.size()) ? fixed[i] : 16'($urandom);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
      loc = (base + i) % DEPTH;
      ref_mem[loc] = w;
      chk("wr_wren", 32'(wren_b), 1);
      chk("wr_addr", 32'(address_b), 32'(loc));
      chk("wr_data", 32'(data_b), 32'(w));
      chk("wr_busy", 32'(busy), (i == cnt - 1) ? 0 : 1);
    end
    if (cnt > 0) begin
      @(negedge clock);
      chk("wr_pulse_end", 32'(wren_b), 0);
    end
    chk("wr_count", 32'(wr_log.size() - wr_idx), 32'(cnt));
    wr_idx = wr_log.size();
  endtask

  // mode 0: tx_ready=1, mode 1: random tx_ready, mode 2: stall 10 cycles
  task automatic do_read(input logic [15:0] a, input int cnt,
                         input int mode);
    int base;
    int n;
    int bad;
    logic [15:0] w;
    base = int'(a) & (DEPTH - 1);
    tx_ready = (mode == 2) ? 1'b0 : 1'b1;
    send_hdr(8'h52, a, 16'(cnt));
    if (cnt == 0) begin
      chk("rd_empty_busy", 32'(busy), 0);
      return;
    end
    chk("rd_lat0", 32'(tx_valid), 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      chk($sformatf("rd_lat%0d", k), 32'(tx_valid), (k == 3) ? 1 : 0);
      chk("rd_rx_ready", 32'(rx_ready), 0);
    end
    if (mode == 2) begin
      w = ref_mem[base];
      for (int k = 0; k < 10; k++) begin
        chk("bp_tx_valid", 32'(tx_valid), 1);
        chk("bp_tx_data", 32'(tx_data), 32'(w[15:8]));
        chk("bp_address_b", 32'(address_b), 32'(base));
        @(negedge clock);
      end
      tx_ready = 1'b1;
    end
    n = 0;
    bad = 0;
    while (busy === 1'b1 && n < 5000) begin
      if (mode == 1) tx_ready = 1'($urandom_range(0, 1));
      if (rx_ready !== 1'b0) bad++;
      @(negedge clock);
      n++;
    end
    tx_ready = 1'b1;
    chk("rd_done", 32'(busy), 0);
    chk("rd_rx_ready_low", 32'(bad), 0);
    if (mode == 0) chk("rd_cycles", 32'(n), 32'(5 * cnt - 3));
    chk("rd_tx_count", 32'(tx_log.size() - tx_idx), 32'(2 * cnt));
    for (int i = 0; i < cnt; i++) begin
      w = ref_mem[(base + i) % DEPTH];
      if (tx_idx < tx_log.size()) chk("rd_hi", 32'(tx_log[tx_idx]), 32'(w[15:8]));
      tx_idx++;
      if (tx_idx < tx_log.size()) chk("rd_lo", 32'(tx_log[tx_idx]), 32'(w[7:0]));
      tx_idx++;
    end
    tx_idx = tx_log.size();
    chk("rd_no_write", 32'(wr_log.size() - wr_idx), 0);
    wr_idx = wr_log.size();
  endtask

  initial begin
    wq_t ws;
    wq_t none;
    logic [7:0] junk;
    int cnt;
    reset    = 1'b1;
    init_go  = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
    @(negedge clock);
    @(negedge clock);
    init_go = 1'b0;
    chk_reset_vals();
    reset = 1'b0;
    @(negedge clock);

    ws = {16'hABCD, 16'h1234};
    do_write(16'h0010, 2, ws);
    do_read(16'h0010, 2, 0);

    ws = {16'h1111, 16'h2222};
    do_write(16'hFFFF, 2, ws);
    do_read(16'h07FF, 2, 0);

    do_read(16'h0010, 2, 2);

    send_byte(8'h41);
    chk("junk_busy", 32'(busy), 0);
    @(negedge clock);
    chk("junk_wren", 32'(wren_b), 0);
    chk("junk_no_write", 32'(wr_log.size() - wr_idx), 0);

    do_write(16'h0020, 0, none);
    chk("empty_no_tx", 32'(tx_log.size() - tx_idx), 0);

    send_hdr(8'h57, 16'h0030, 16'h0001);
    send_byte(8'hAB);
    #2 reset = 1'b1;
    #1 chk_reset_vals();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_no_write", 32'(wr_log.size() - wr_idx), 0);
    ws = {16'h5555};
    do_write(16'h0030, 1, ws);
    do_read(16'h0030, 1, 0);

    for (int t = 0; t < 14; t++) begin
      cnt = $urandom_range(1, 5);
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom);
        if (junk == 8'h57 || junk == 8'h52) junk = 8'h00;
        send_byte(junk);
        chk("rnd_junk_busy", 32'(busy), 0);
      end
      if ($urandom_range(0, 1) == 1)
        do_write(16'($urandom), cnt, none);
      else
        do_read(16'($urandom), cnt, $urandom_range(0, 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
